// File: rtl/aud_mix_pkg.sv
// Shared types and constants for the multi-channel stereo audio mixer.
package aud_mix_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ACC,
        XF,
        ATT,
        OUT
    } state_e;

    localparam int unsigned GW        = 5;
    localparam logic [4:0]  MUTE_GAIN = 5'd16;

    localparam logic [1:0] XF_NONE = 2'd0;
    localparam logic [1:0] XF_8    = 2'd1;
    localparam logic [1:0] XF_4    = 2'd2;
    localparam logic [1:0] XF_HALF = 2'd3;

    // Accumulator width: sample width plus channel growth plus one guard bit.
    function automatic int unsigned acc_width(input int unsigned nch, input int unsigned dw);
        return dw + unsigned'($clog2(nch)) + 32'd1;
    endfunction

endpackage

// File: rtl/aud_gain_ramp.sv
// One channel's gain register: steps by one toward its target on each accepted sample.
module aud_gain_ramp
    import aud_mix_pkg::*;
(
    input  logic          clk,
    input  logic          reset_n,
    input  logic          step_i,
    input  logic [GW-1:0] att_i,
    output logic [GW-1:0] gain_o
);

    logic [GW-1:0] gain_q;
    logic [GW-1:0] gain_d;
    logic [GW-1:0] target_c;

    assign target_c = att_i[4] ? MUTE_GAIN : {1'b0, att_i[3:0]};

    always_comb begin
        gain_d = gain_q;
        if (step_i) begin
            if (gain_q < target_c) begin
                gain_d = gain_q + 5'd1;
            end else if (gain_q > target_c) begin
                gain_d = gain_q - 5'd1;
            end
        end
    end

    // Reset to muted so channels fade in after reset instead of popping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gain_q <= MUTE_GAIN;
        end else begin
            gain_q <= gain_d;
        end
    end

    assign gain_o = gain_q;

endmodule

// File: rtl/aud_mix_multi.sv
// Multi-channel stereo mixer: per-channel ramped attenuation, sequential accumulate,
// crossfeed, master attenuation and saturation to the output sample width.
module aud_mix_multi
    import aud_mix_pkg::*;
#(
    parameter int unsigned NCH = 4,
    parameter int unsigned DW  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ce,
    input  logic [NCH*DW-1:0] in_l,
    input  logic [NCH*DW-1:0] in_r,
    input  logic [NCH*5-1:0]  ch_att,
    input  logic [1:0]        mix,
    input  logic [4:0]        master_att,
    output logic [DW-1:0]     out_l,
    output logic [DW-1:0]     out_r,
    output logic              out_valid,
    output logic              busy,
    output logic              clip,
    output logic              overrun
);

    localparam int unsigned AW = acc_width(NCH, DW);
    localparam int unsigned XW = AW + 1;
    localparam int unsigned IW = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic signed [XW-1:0] SAT_MAX = {{(XW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [XW-1:0] SAT_MIN = {{(XW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    state_e               state_q, state_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [NCH*DW-1:0]    snap_l_q, snap_l_d;
    logic [NCH*DW-1:0]    snap_r_q, snap_r_d;
    logic [1:0]           mix_q, mix_d;
    logic signed [AW-1:0] acc_l_q, acc_l_d;
    logic signed [AW-1:0] acc_r_q, acc_r_d;
    logic signed [XW-1:0] xf_l_q, xf_l_d;
    logic signed [XW-1:0] xf_r_q, xf_r_d;
    logic [DW-1:0]        out_l_q, out_l_d;
    logic [DW-1:0]        out_r_q, out_r_d;
    logic                 out_valid_q, out_valid_d;
    logic                 busy_q, busy_d;
    logic                 clip_q, clip_d;
    logic                 overrun_q, overrun_d;

    logic                 accept_c;
    logic [GW-1:0]        gain [NCH];
    logic signed [DW-1:0] smp_l_c, smp_r_c;
    logic [GW-1:0]        gsel_c;
    logic signed [XW-1:0] att_l_c, att_r_c;
    logic [DW:0]          sat_l_c, sat_r_c;

    // Arithmetic-shift one sample into accumulator width; a muted gain contributes nothing.
    function automatic logic signed [AW-1:0] scale(input logic signed [DW-1:0] s,
                                                   input logic [GW-1:0]        g);
        logic signed [AW-1:0] ext;
        ext = AW'(s);
        if (g >= MUTE_GAIN) begin
            return '0;
        end
        return ext >>> g[3:0];
    endfunction

    // Crossfeed of channel a with the opposite channel b; call with arguments swapped for R.
    function automatic logic signed [XW-1:0] xfeed(input logic signed [AW-1:0] a,
                                                   input logic signed [AW-1:0] b,
                                                   input logic [1:0]           m);
        logic signed [XW-1:0] x;
        logic signed [XW-1:0] y;
        logic signed [XW-1:0] r;
        x = XW'(a);
        y = XW'(b);
        r = x;
        case (m)
            XF_NONE: r = x;
            XF_8:    r = x - (x >>> 3) + (y >>> 3);
            XF_4:    r = x - (x >>> 2) + (y >>> 2);
            XF_HALF: r = (x >>> 1) + (y >>> 1);
        endcase
        return r;
    endfunction

    // Clamp to DW signed; the MSB of the result flags that clamping happened.
    function automatic logic [DW:0] saturate(input logic signed [XW-1:0] x);
        if (x > SAT_MAX) begin
            return {1'b1, 1'b0, {(DW-1){1'b1}}};
        end
        if (x < SAT_MIN) begin
            return {1'b1, 1'b1, {(DW-1){1'b0}}};
        end
        return {1'b0, x[DW-1:0]};
    endfunction

    // A sample is taken when idle or in the output cycle; anything else is an overrun.
    assign accept_c = ce && ((state_q == IDLE) || (state_q == OUT));

    for (genvar k = 0; k < NCH; k++) begin : gen_ramp
        aud_gain_ramp u_ramp (
            .clk     (clk),
            .reset_n (reset_n),
            .step_i  (accept_c),
            .att_i   (ch_att[k*GW +: GW]),
            .gain_o  (gain[k])
        );
    end

    always_comb begin
        smp_l_c = '0;
        smp_r_c = '0;
        gsel_c  = MUTE_GAIN;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (idx_q == IW'(k)) begin
                smp_l_c = snap_l_q[k*DW +: DW];
                smp_r_c = snap_r_q[k*DW +: DW];
                gsel_c  = gain[k];
            end
        end
    end

    always_comb begin
        att_l_c = '0;
        att_r_c = '0;
        if (!master_att[4]) begin
            att_l_c = xf_l_q >>> master_att[3:0];
            att_r_c = xf_r_q >>> master_att[3:0];
        end
    end

    assign sat_l_c = saturate(att_l_c);
    assign sat_r_c = saturate(att_r_c);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        snap_l_d    = snap_l_q;
        snap_r_d    = snap_r_q;
        mix_d       = mix_q;
        acc_l_d     = acc_l_q;
        acc_r_d     = acc_r_q;
        xf_l_d      = xf_l_q;
        xf_r_d      = xf_r_q;
        out_l_d     = out_l_q;
        out_r_d     = out_r_q;
        out_valid_d = 1'b0;
        clip_d      = clip_q;
        overrun_d   = overrun_q | (ce & ~accept_c);
        case (state_q)
            IDLE, OUT: begin
                state_d = IDLE;
                if (accept_c) begin
                    snap_l_d = in_l;
                    snap_r_d = in_r;
                    mix_d    = mix;
                    acc_l_d  = '0;
                    acc_r_d  = '0;
                    idx_d    = '0;
                    state_d  = ACC;
                end
            end
            ACC: begin
                acc_l_d = acc_l_q + scale(smp_l_c, gsel_c);
                acc_r_d = acc_r_q + scale(smp_r_c, gsel_c);
                if (idx_q == IW'(NCH - 1)) begin
                    state_d = XF;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            XF: begin
                xf_l_d  = xfeed(acc_l_q, acc_r_q, mix_q);
                xf_r_d  = xfeed(acc_r_q, acc_l_q, mix_q);
                state_d = ATT;
            end
            // Outputs are captured on the edge into OUT so out_valid lands NCH+3 cycles after ce.
            ATT: begin
                out_l_d     = sat_l_c[DW-1:0];
                out_r_d     = sat_r_c[DW-1:0];
                clip_d      = clip_q | sat_l_c[DW] | sat_r_c[DW];
                out_valid_d = 1'b1;
                state_d     = OUT;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == ACC) || (state_d == XF) || (state_d == ATT);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            snap_l_q    <= '0;
            snap_r_q    <= '0;
            mix_q       <= '0;
            acc_l_q     <= '0;
            acc_r_q     <= '0;
            xf_l_q      <= '0;
            xf_r_q      <= '0;
            out_l_q     <= '0;
            out_r_q     <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            clip_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            snap_l_q    <= snap_l_d;
            snap_r_q    <= snap_r_d;
            mix_q       <= mix_d;
            acc_l_q     <= acc_l_d;
            acc_r_q     <= acc_r_d;
            xf_l_q      <= xf_l_d;
            xf_r_q      <= xf_r_d;
            out_l_q     <= out_l_d;
            out_r_q     <= out_r_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            clip_q      <= clip_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out_l     = out_l_q;
    assign out_r     = out_r_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign clip      = clip_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_aud_mix_multi.sv
// Directed bench for aud_mix_multi: expected samples are queued at ce and checked on out_valid.
module tb_aud_mix_multi;

    localparam int NCH = 4;
    localparam int DW  = 16;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              ce;
    logic [NCH*DW-1:0] in_l;
    logic [NCH*DW-1:0] in_r;
    logic [NCH*5-1:0]  ch_att;
    logic [1:0]        mix;
    logic [4:0]        master_att;
    logic [DW-1:0]     out_l;
    logic [DW-1:0]     out_r;
    logic              out_valid;
    logic              busy;
    logic              clip;
    logic              overrun;

    aud_mix_multi #(.NCH(NCH), .DW(DW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ce         (ce),
        .in_l       (in_l),
        .in_r       (in_r),
        .ch_att     (ch_att),
        .mix        (mix),
        .master_att (master_att),
        .out_l      (out_l),
        .out_r      (out_r),
        .out_valid  (out_valid),
        .busy       (busy),
        .clip       (clip),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int seq;
        int l;
        int r;
        int ce_cyc;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    int   seq_n = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NCH*DW-1:0] pack4(input int a, input int b, input int c, input int d);
        return {DW'(d), DW'(c), DW'(b), DW'(a)};
    endfunction

    task automatic push_exp(input int el, input int er);
        exp_t e;
        e.seq    = seq_n;
        e.l      = el;
        e.r      = er;
        e.ce_cyc = cyc;
        seq_n++;
        sb.push_back(e);
    endtask

    // Drive one ce with the given inputs, queue its expected result and let it complete.
    task automatic sample(input logic [NCH*DW-1:0] l, input logic [NCH*DW-1:0] r,
                          input logic [1:0] m, input int el, input int er);
        in_l = l;
        in_r = r;
        mix  = m;
        ce   = 1'b1;
        push_exp(el, er);
        tick();
        ce = 1'b0;
        repeat (NCH + 3) tick();
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (out_valid === 1'b1) begin
            check("valid_has_expectation", (sb.size() != 0) ? 1 : 0, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check($sformatf("out_l#%0d", e.seq), $signed(out_l), e.l);
                check($sformatf("out_r#%0d", e.seq), $signed(out_r), e.r);
                check($sformatf("latency#%0d", e.seq), cyc - e.ce_cyc, NCH + 3);
            end
        end
    end

    initial begin
        reset_n    = 1'b0;
        ce         = 1'b0;
        in_l       = '0;
        in_r       = '0;
        ch_att     = '0;
        mix        = 2'd0;
        master_att = 5'd0;
        repeat (3) tick();

        check("rst_out_l", $signed(out_l), 0);
        check("rst_out_r", $signed(out_r), 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_clip", clip, 0);
        check("rst_overrun", overrun, 0);

        reset_n = 1'b1;
        tick();

        // Gains come out of reset at 16 and step to 15 on the first sample: -32768>>>15 = -1 per channel.
        sample(pack4(-32768, -32768, -32768, -32768), pack4(-32768, -32768, -32768, -32768),
               2'd0, -4, -4);
        repeat (15) sample('0, '0, 2'd0, 0, 0);

        // Basic sum with busy timing, then a ce in the out_valid cycle.
        in_l = pack4(1000, 2000, 3000, 4000);
        in_r = pack4(-500, -500, -500, -500);
        mix  = 2'd0;
        ce   = 1'b1;
        push_exp(10000, -2000);
        check("busy_in_ce_cycle", busy, 0);
        tick();
        ce = 1'b0;
        check("busy_rise", busy, 1);
        repeat (NCH + 1) tick();
        check("busy_before_out", busy, 1);
        tick();
        check("busy_in_out_cycle", busy, 0);
        check("valid_in_out_cycle", out_valid, 1);
        in_l = pack4(1, 2, 3, 4);
        in_r = pack4(-1, -2, -3, -4);
        ce   = 1'b1;
        push_exp(10, -10);
        tick();
        ce = 1'b0;
        check("busy_back_to_back", busy, 1);
        repeat (NCH + 3) tick();
        check("overrun_back_to_back", overrun, 0);
        repeat (3) tick();
        check("hold_out_l", $signed(out_l), 10);
        check("hold_out_r", $signed(out_r), -10);
        check("clip_before_clamp", clip, 0);

        // Clamping.
        sample(pack4(16000, 16000, 16000, 16000), '0, 2'd0, 32767, 0);
        check("clip_set", clip, 1);
        sample(pack4(-16000, -16000, -16000, -16000), '0, 2'd0, -32768, 0);
        sample('0, '0, 2'd0, 0, 0);
        check("clip_sticky", clip, 1);

        // Crossfeed modes.
        sample(pack4(8000, 0, 0, 0), '0, 2'd3, 4000, 4000);
        sample(pack4(8000, 0, 0, 0), '0, 2'd1, 7000, 1000);
        sample(pack4(8000, 0, 0, 0), '0, 2'd2, 6000, 2000);
        sample('0, pack4(0, 0, 0, 8000), 2'd1, 1000, 7000);
        sample(pack4(-8000, 0, 0, 0), '0, 2'd1, -7000, -1000);

        // Master attenuation.
        master_att = 5'd2;
        sample(pack4(1000, 2000, 3000, 4000), pack4(100, 200, 300, 400), 2'd0, 2500, 250);
        master_att = 5'h10;
        sample(pack4(1000, 2000, 3000, 4000), pack4(100, 200, 300, 400), 2'd0, 0, 0);
        master_att = 5'd0;

        // Channel 0 ramps to mute one step per sample.
        ch_att = {5'd0, 5'd0, 5'd0, 5'h10};
        for (int n = 1; n <= 18; n++) begin
            sample(pack4(4096, 0, 0, 0), '0, 2'd0, (n < 13) ? (4096 >> n) : 0, 0);
        end

        // ce two cycles into a sample is dropped and flagged.
        in_l = pack4(0, 100, 200, 300);
        in_r = '0;
        mix  = 2'd0;
        ce   = 1'b1;
        push_exp(600, 0);
        tick();
        ce = 1'b0;
        tick();
        in_l = pack4(5000, 5000, 5000, 5000);
        ce   = 1'b1;
        tick();
        ce = 1'b0;
        check("overrun_set", overrun, 1);
        repeat (NCH + 4) tick();
        check("overrun_sticky", overrun, 1);

        // Reset in the middle of accumulation.
        ch_att = '0;
        in_l   = pack4(1000, 2000, 3000, 4000);
        ce     = 1'b1;
        tick();
        ce = 1'b0;
        tick();
        check("busy_before_reset", busy, 1);
        reset_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_out_l", $signed(out_l), 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_clip", clip, 0);
        check("midrst_overrun", overrun, 0);
        tick();
        tick();
        reset_n = 1'b1;
        repeat (NCH + 5) tick();
        check("no_valid_after_abort", sb.size(), 0);
        sample(pack4(-32768, -32768, -32768, -32768), pack4(-32768, -32768, -32768, -32768),
               2'd0, -4, -4);

        repeat (2) tick();
        check("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/aud_mix_multi.md
AUD_MIX_MULTI -- requirements
Module: aud_mix_multi

Interface
REQ-001 SHALL have parameter NCH, default 4, number of stereo input channels (legal 2..8).
REQ-002 SHALL have parameter DW, default 16, sample width in bits (legal 12..24), two's complement.
REQ-003 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port ce  input  1  sample strobe; one pulse per output sample.
REQ-006 SHALL have port in_l  input  NCH*DW  left samples, channel k at bits [k*DW +: DW].
REQ-007 SHALL have port in_r  input  NCH*DW  right samples, packed the same way as in_l.
REQ-008 SHALL have port ch_att  input  NCH*5  per-channel attenuation; bit4 = mute, bits3:0 = right-shift amount.
REQ-009 SHALL have port mix  input  2  stereo crossfeed mode.
REQ-010 SHALL have port master_att  input  5  master attenuation; bit4 = mute, bits3:0 = shift amount.
REQ-011 SHALL have port out_l, out_r  output  DW each  mixed and clamped stereo result.
REQ-012 SHALL have port out_valid  output  1  one-cycle pulse when out_l/out_r update.
REQ-013 SHALL have port busy  output  1  high while a sample is being processed.
REQ-014 SHALL have port clip  output  1  sticky flag: some output was clamped since reset.
REQ-015 SHALL have port overrun  output  1  sticky flag: ce arrived while busy.

Function
REQ-016 On ce while IDLE, SHALL snapshot in_l, in_r and mix, and enter ACC; busy rises in the next cycle.
REQ-017 ACC SHALL add one channel per cycle (k = 0..NCH-1), each sample arithmetic-shifted right by its current gain g[k], into a signed accumulator of width AW = DW + clog2(NCH) + 1.
REQ-018 In ACC, channel g[k] = 16 SHALL contribute 0.
REQ-019 After ACC, SHALL apply crossfeed in the XF state; L and R are full accumulator values.
REQ-020 Crossfeed mode 0: L' = L.
REQ-021 Crossfeed mode 1: L' = L - L/8 + R/8.
REQ-022 Crossfeed mode 2: L' = L - L/4 + R/4.
REQ-023 Crossfeed mode 3: L' = L/2 + R/2.
REQ-024 For all crossfeed modes: R' is the symmetric expression; "/2^n" is an arithmetic shift; the result width is AW+1.
REQ-025 In ATT, SHALL apply master_att to both channels: bit4 forces 0, otherwise arithmetic shift right by bits3:0.
REQ-026 In OUT, SHALL saturate each channel to DW signed: +(2^(DW-1)-1) or -2^(DW-1).
REQ-027 OUT SHALL register out_l and out_r, pulse out_valid for 1 cycle, set clip if either channel saturated, and return to IDLE.
REQ-028 Latency SHALL be exactly NCH+3 cycles from the ce cycle to the out_valid cycle; busy covers that span.
REQ-029 A ce that arrives when busy is high SHALL be ignored and SHALL set overrun.
REQ-030 A ce in the same cycle as out_valid SHALL be accepted.
REQ-031 The gain ramp g[k] (range 0..16) SHALL step once per accepted ce, before ACC, by 1 toward target t[k]: t[k] = 16 if ch_att[k] bit4 is set, else bits3:0; it holds when equal.
REQ-032 out_l and out_r SHALL hold their value between out_valid pulses.
REQ-033 clip and overrun SHALL clear only on reset.

Reset
REQ-034 While reset_n is low, the FSM SHALL be in IDLE and out_l, out_r, out_valid, busy, clip and overrun SHALL all be 0.
REQ-035 While reset_n is low, every g[k] SHALL be 16 (muted), so channels ramp in after reset with no pop.
REQ-036 Reset asserted mid-operation SHALL abort the sample with no out_valid; the first ce after release starts a clean sample.

Structure
REQ-037 A shared package aud_mix_pkg SHALL hold: the FSM state enum (IDLE, ACC, XF, ATT, OUT), the MUTE_GAIN = 16 constant, the crossfeed mode constants, and the AW width function.
REQ-038 A sub-module aud_gain_ramp SHALL implement one channel's g[k] register and be instantiated NCH times.
REQ-039 The saturation logic SHALL be shared by both channels in a single function.

Verification
REQ-040 Bench scenario, basic sum: NCH=4, DW=16, all ch_att=0 after the ramp settles, mix=0, master_att=0, in_l channels = 1000, 2000, 3000, 4000 -> out_l=10000, and out_valid exactly 7 cycles after ce.
REQ-041 Bench scenario, clamping: all four in_l channels = 16000 -> out_l=32767 and clip=1; all four = -16000 -> out_l=-32768.
REQ-042 Bench scenario, crossfeed: mix=3, summed L=8000 and R=0 -> out_l=4000 and out_r=4000; with mix=1 the same input -> out_l=7000 and out_r=1000.
REQ-043 Bench scenario, ramp: ch_att[0] goes 0 -> 5'h10 with in_l[0]=4096 and all other channels 0 -> successive out_l = 2048, 1024, ..., 1, then 0 from the 13th sample onward, and 0 on every later sample.
REQ-044 Bench scenario, overrun: ce pulsed 2 cycles after an accepted ce -> overrun=1, no extra out_valid, and the first result is unchanged.
REQ-045 Bench scenario, reset: reset_n driven low during ACC -> busy=0 and out_l=0 immediately, no out_valid follows, and all g[k]=16 on release.
